// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel to 1-output mux/arbiter.
//   MODE_FIXED / MODE_RR : operating mode constants for the MODE parameter
//   out_state_e          : output stage state (EMPTY / FULL)
//   clog2()              : ceiling log2, minimum result 1, used to size selects
package mux_pkg;

  localparam int MODE_FIXED = 32'sd0;
  localparam int MODE_RR    = 32'sd1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 32'sd1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 32'sd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_nch_1out_rr_arbiter.sv
// Round-robin priority selector (purely combinational).
//   req       : per-channel request vector
//   ptr       : channel that currently has highest priority
//   gnt_valid : at least one request is present
//   gnt_idx   : first requesting channel scanning ptr, ptr+1, ... (mod N_CH)
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]          req,
  input  logic [clog2(N_CH)-1:0]   ptr,
  output logic                     gnt_valid,
  output logic [clog2(N_CH)-1:0]   gnt_idx
);

  localparam int SEL_W = clog2(N_CH);
  localparam int PAD_N = 32'sd1 << SEL_W;

  logic [PAD_N-1:0] req_pad_s;

  // Zero-extend req so any SEL_W-bit index is in range.
  always_comb begin
    req_pad_s = '0;
    req_pad_s[N_CH-1:0] = req;
  end

  // Scan from the farthest offset down to ptr so the closest requester wins.
  always_comb begin
    int idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_CH;
      if (req_pad_s[SEL_W'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(idx);
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/mux_arb_nch_1out.sv
// N-channel to 1-output multiplexer with a one-word registered output stage.
//   clk, rst          : clock, synchronous active-high reset
//   I, I_valid, I_ready : upstream channels (channel k at I[k*W +: W])
//   sel               : channel select (MODE_FIXED only)
//   Q, Q_valid, Q_ready : registered downstream handshake
//   Q_ch              : index of the channel that sourced Q
module mux_arb_nch_1out
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 1,
  parameter int MODE = MODE_FIXED
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*W-1:0]      I,
  input  logic [N_CH-1:0]        I_valid,
  output logic [N_CH-1:0]        I_ready,
  input  logic [clog2(N_CH)-1:0] sel,
  output logic [W-1:0]           Q,
  output logic                   Q_valid,
  input  logic                   Q_ready,
  output logic [clog2(N_CH)-1:0] Q_ch
);

  localparam int SEL_W = clog2(N_CH);
  localparam int PAD_N = 32'sd1 << SEL_W;

  out_state_e       state_q, state_d;
  logic [W-1:0]     q_q, q_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [PAD_N-1:0] valid_pad_s;
  logic             rr_gnt_valid_s;
  logic [SEL_W-1:0] rr_gnt_idx_s;
  logic             gnt_valid_s;
  logic [SEL_W-1:0] gnt_idx_s;
  logic             load_s;
  logic             accept_s;
  logic [W-1:0]     din_s;

  rr_arbiter #(.N_CH(N_CH)) u_rr (
    .req       (I_valid),
    .ptr       (ptr_q),
    .gnt_valid (rr_gnt_valid_s),
    .gnt_idx   (rr_gnt_idx_s)
  );

  // Zero-extend I_valid so an out-of-range sel reads as "no request".
  always_comb begin
    valid_pad_s = '0;
    valid_pad_s[N_CH-1:0] = I_valid;
  end

  // Grant source depends on mode; load when empty or the held word drains.
  always_comb begin
    if (MODE == MODE_RR) begin
      gnt_valid_s = rr_gnt_valid_s;
      gnt_idx_s   = rr_gnt_idx_s;
    end else begin
      gnt_valid_s = valid_pad_s[sel];
      gnt_idx_s   = sel;
    end
    load_s   = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && Q_ready);
    accept_s = load_s && gnt_valid_s && !rst;
  end

  // One-hot ready and data mux on the granted channel.
  always_comb begin
    I_ready = '0;
    din_s   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_idx_s == SEL_W'(k)) begin
        I_ready[k] = accept_s;
        din_s      = I[k*W +: W];
      end else begin
        I_ready[k] = 1'b0;
      end
    end
  end

  // Next-state for the output stage and round-robin pointer.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (load_s) begin
      if (accept_s) begin
        state_d = ST_FULL;
        q_d     = din_s;
        ch_d    = gnt_idx_s;
        if (MODE == MODE_RR) begin
          ptr_d = (gnt_idx_s == SEL_W'(N_CH - 1)) ? '0 : gnt_idx_s + SEL_W'(1);
        end else begin
          ptr_d = '0;
        end
      end else begin
        // Empty slot with nothing granted: Q and Q_ch keep their old values.
        state_d = ST_EMPTY;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output stage state machine and pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      q_q     <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Q       = q_q;
  assign Q_ch    = ch_q;
  assign Q_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_mux_arb_nch_1out.sv
module tb_mux_arb_nch_1out;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // DUT 0: N_CH=4, W=8, fixed select
  logic        rst0, qr0, qv0;
  logic [31:0] din0;
  logic [3:0]  v0, ir0;
  logic [1:0]  sel0, qch0;
  logic [7:0]  q0;

  // DUT 1: N_CH=4, W=8, round robin
  logic        rst1, qr1, qv1;
  logic [31:0] din1;
  logic [3:0]  v1, ir1;
  logic [1:0]  sel1, qch1;
  logic [7:0]  q1;

  // DUT 2: N_CH=3, W=8, fixed select
  logic        rst2, qr2, qv2;
  logic [23:0] din2;
  logic [2:0]  v2, ir2;
  logic [1:0]  sel2, qch2;
  logic [7:0]  q2;

  mux_arb_nch_1out #(.N_CH(4), .W(8), .MODE(0)) u0 (
    .clk(clk), .rst(rst0), .I(din0), .I_valid(v0), .I_ready(ir0), .sel(sel0),
    .Q(q0), .Q_valid(qv0), .Q_ready(qr0), .Q_ch(qch0));

  mux_arb_nch_1out #(.N_CH(4), .W(8), .MODE(1)) u1 (
    .clk(clk), .rst(rst1), .I(din1), .I_valid(v1), .I_ready(ir1), .sel(sel1),
    .Q(q1), .Q_valid(qv1), .Q_ready(qr1), .Q_ch(qch1));

  mux_arb_nch_1out #(.N_CH(3), .W(8), .MODE(0)) u2 (
    .clk(clk), .rst(rst2), .I(din2), .I_valid(v2), .I_ready(ir2), .sel(sel2),
    .Q(q2), .Q_valid(qv2), .Q_ready(qr2), .Q_ch(qch2));

  typedef struct {
    logic        rst;
    logic [1:0]  sel;
    logic [31:0] din;
    logic [3:0]  vld;
    logic        qr;
    logic [3:0]  e_ir;
    logic        e_qv;
    logic [7:0]  e_q;
    logic [1:0]  e_ch;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One round-robin cycle on DUT 1 with Q_ready=1; ech is the expected grant.
  task automatic rr_step(input string nm, input logic [3:0] vld, input int ech);
    logic [31:0] d;
    logic [3:0]  one;
    d   = 32'hD3C2B1A0;
    one = 4'b0001;
    v1  = vld;
    qr1 = 1'b1;
    @(negedge clk);
    chk({nm, " I_ready"}, 32'(ir1), 32'(one << ech));
    @(posedge clk); #1;
    chk({nm, " Q_valid"}, 32'(qv1), 32'd1);
    chk({nm, " Q_ch"}, 32'(qch1), 32'(ech));
    chk({nm, " Q"}, 32'(q1), 32'(d[ech*8 +: 8]));
  endtask

  initial begin
    rst0 = 1'b1; qr0 = 1'b0; din0 = '0; v0 = '0; sel0 = '0;
    rst1 = 1'b1; qr1 = 1'b0; din1 = 32'hD3C2B1A0; v1 = '0; sel1 = '0;
    rst2 = 1'b1; qr2 = 1'b0; din2 = 24'h332211; v2 = '0; sel2 = '0;

    //             rst   sel   din            vld     qr    e_ir    e_qv  e_q    e_ch
    tbl[0]  = '{1'b1, 2'd0, 32'h11A52233, 4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0};
    tbl[1]  = '{1'b1, 2'd0, 32'h11A52233, 4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0};
    tbl[2]  = '{1'b0, 2'd2, 32'h11A52233, 4'h4, 1'b1, 4'h4, 1'b1, 8'hA5, 2'd2};
    tbl[3]  = '{1'b0, 2'd1, 32'h11A52233, 4'h2, 1'b1, 4'h2, 1'b1, 8'h22, 2'd1};
    tbl[4]  = '{1'b0, 2'd3, 32'h11A52233, 4'h0, 1'b1, 4'h0, 1'b0, 8'h22, 2'd1};
    tbl[5]  = '{1'b0, 2'd0, 32'h4455663C, 4'h1, 1'b0, 4'h1, 1'b1, 8'h3C, 2'd0};
    tbl[6]  = '{1'b0, 2'd2, 32'hDEADBEEF, 4'hF, 1'b0, 4'h0, 1'b1, 8'h3C, 2'd0};
    tbl[7]  = '{1'b0, 2'd3, 32'h01020304, 4'hF, 1'b0, 4'h0, 1'b1, 8'h3C, 2'd0};
    tbl[8]  = '{1'b0, 2'd1, 32'hCAFEF00D, 4'hF, 1'b0, 4'h0, 1'b1, 8'h3C, 2'd0};
    tbl[9]  = '{1'b0, 2'd1, 32'h99887766, 4'hF, 1'b1, 4'h2, 1'b1, 8'h77, 2'd1};
    tbl[10] = '{1'b0, 2'd1, 32'h99887766, 4'h0, 1'b1, 4'h0, 1'b0, 8'h77, 2'd1};

    @(posedge clk); #1;

    // Fixed-select table on DUT 0
    for (int i = 0; i < 11; i++) begin
      rst0 = tbl[i].rst; sel0 = tbl[i].sel; din0 = tbl[i].din;
      v0 = tbl[i].vld; qr0 = tbl[i].qr;
      @(negedge clk);
      chk($sformatf("row%0d I_ready", i), 32'(ir0), 32'(tbl[i].e_ir));
      @(posedge clk); #1;
      chk($sformatf("row%0d Q_valid", i), 32'(qv0), 32'(tbl[i].e_qv));
      chk($sformatf("row%0d Q", i), 32'(q0), 32'(tbl[i].e_q));
      chk($sformatf("row%0d Q_ch", i), 32'(qch0), 32'(tbl[i].e_ch));
    end

    // Round-robin sweep, skip and wrap, then reset clears the pointer
    rst1 = 1'b1; v1 = 4'hF; qr1 = 1'b1;
    @(negedge clk);
    chk("rr rst I_ready", 32'(ir1), 32'd0);
    @(posedge clk); #1;
    chk("rr rst Q_valid", 32'(qv1), 32'd0);
    rst1 = 1'b0;
    rr_step("sweep0", 4'hF, 0);
    rr_step("sweep1", 4'hF, 1);
    rr_step("sweep2", 4'hF, 2);
    rr_step("sweep3", 4'hF, 3);
    rr_step("sweep4", 4'hF, 0);
    rr_step("sweep5", 4'hF, 1);
    rr_step("toptr3", 4'b0100, 2);
    rr_step("skip0", 4'b0101, 0);
    rr_step("skip1", 4'b0101, 2);
    rr_step("skip2", 4'b0101, 0);
    rst1 = 1'b1; v1 = 4'hF;
    @(negedge clk);
    chk("rr midrst I_ready", 32'(ir1), 32'd0);
    @(posedge clk); #1;
    chk("rr midrst Q_valid", 32'(qv1), 32'd0);
    rst1 = 1'b0;
    rr_step("afterrst", 4'hF, 0);

    // Three-channel fixed select: invalid sel, then reset while FULL
    rst2 = 1'b1;
    @(posedge clk); #1;
    chk("n3 rst Q_valid", 32'(qv2), 32'd0);
    rst2 = 1'b0; sel2 = 2'd3; v2 = 3'b111; qr2 = 1'b1;
    @(negedge clk);
    chk("n3 sel3 I_ready", 32'(ir2), 32'd0);
    @(posedge clk); #1;
    chk("n3 sel3 Q_valid", 32'(qv2), 32'd0);
    sel2 = 2'd1;
    @(negedge clk);
    chk("n3 sel1 I_ready", 32'(ir2), 32'b010);
    @(posedge clk); #1;
    chk("n3 sel1 Q_valid", 32'(qv2), 32'd1);
    chk("n3 sel1 Q", 32'(q2), 32'h22);
    chk("n3 sel1 Q_ch", 32'(qch2), 32'd1);
    rst2 = 1'b1; qr2 = 1'b0; sel2 = 2'd2;
    @(negedge clk);
    chk("n3 midrst I_ready", 32'(ir2), 32'd0);
    @(posedge clk); #1;
    chk("n3 midrst Q_valid", 32'(qv2), 32'd0);
    chk("n3 midrst Q", 32'(q2), 32'd0);
    chk("n3 midrst Q_ch", 32'(qch2), 32'd0);
    rst2 = 1'b0;
    @(negedge clk);
    chk("n3 reload I_ready", 32'(ir2), 32'b100);
    @(posedge clk); #1;
    chk("n3 reload Q_valid", 32'(qv2), 32'd1);
    chk("n3 reload Q", 32'(q2), 32'h33);
    chk("n3 reload Q_ch", 32'(qch2), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
